// File: rtl/bram_pkg.sv
// Shared constants and helpers for the pipelined simple-dual-port block RAM.
// Holds the write-mode encodings, lane derivation, lane parity and legal read-latency range.
package bram_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 4;

    // Widest lane the parity helper accepts; narrower lanes are zero-extended.
    localparam int MAX_LANE_BITS = 64;

    function automatic int lane_count(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    function automatic bit read_latency_legal(input int latency);
        return (latency >= READ_LATENCY_MIN) && (latency <= READ_LATENCY_MAX);
    endfunction

    // Even parity: the stored bit makes the total count of ones in lane+bit even.
    function automatic logic lane_parity(input logic [MAX_LANE_BITS-1:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/bram_sdp_core.sv
// Storage array with per-lane masked write, read/write collision mux and the stage-1 read register.
// With BRAM_PARITY_EN defined, a parity bit per lane is stored and forwarded beside the data.
module bram_sdp_core
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 11,
    parameter int BYTE_WIDTH    = 8,
    parameter int WRITE_MODE    = READ_FIRST,
    parameter int LANES         = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     ren,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    input  logic                     wen,
    input  logic [LANES-1:0]         wmask,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    din,
`ifdef BRAM_PARITY_EN
    input  logic                     perr_inject,
    output logic [LANES-1:0]         rpar,
`endif
    output logic [DATA_WIDTH-1:0]    rdata
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  collide;
    logic                  forward;

    assign old_word = mem[raddr];
    assign collide  = ren & wen & (raddr == waddr);
    assign forward  = (WRITE_MODE == WRITE_FIRST) & collide;

`ifdef BRAM_PARITY_EN
    logic [LANES-1:0] par_mem [DEPTH];
    logic [LANES-1:0] old_par;
    logic [LANES-1:0] new_par;
    logic [LANES-1:0] merged_par;
    logic [LANES-1:0] rpar_reg;

    assign old_par = par_mem[raddr];
`endif

    // Merged word is what the array will hold after this edge's write.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign merged_word[gi*BYTE_WIDTH +: BYTE_WIDTH] =
            wmask[gi] ? din[gi*BYTE_WIDTH +: BYTE_WIDTH] : old_word[gi*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef BRAM_PARITY_EN
        assign new_par[gi] =
            lane_parity(MAX_LANE_BITS'(din[gi*BYTE_WIDTH +: BYTE_WIDTH])) ^ perr_inject;
        assign merged_par[gi] = wmask[gi] ? new_par[gi] : old_par[gi];
`endif
    end

    always_ff @(posedge clock) begin
        if (wen) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask[i]) begin
                    mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef BRAM_PARITY_EN
                    par_mem[waddr][i] <= new_par[i];
`endif
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_reg <= '0;
`ifdef BRAM_PARITY_EN
            rpar_reg  <= '0;
`endif
        end else if (ren) begin
            rdata_reg <= forward ? merged_word : old_word;
`ifdef BRAM_PARITY_EN
            rpar_reg  <= forward ? merged_par : old_par;
`endif
        end
    end

    assign rdata = rdata_reg;
`ifdef BRAM_PARITY_EN
    assign rpar  = rpar_reg;
`endif

endmodule

// File: rtl/bram_pipelined_sdp.sv
// Simple-dual-port block RAM with byte-lane write masks, 1..4 cycle read pipeline and collision mode.
// Optional per-lane parity is enabled by defining BRAM_PARITY_EN (adds the perr_inject port).
module bram_pipelined_sdp
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 11,
    parameter int BYTE_WIDTH    = 8,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_MODE    = READ_FIRST,
    parameter     FILENAME      = ""
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  ren,
    input  logic [ADDRESS_WIDTH-1:0]              raddr,
    output logic [DATA_WIDTH-1:0]                 dout,
    output logic                                  dout_valid,
    input  logic                                  wen,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]      wmask,
    input  logic [ADDRESS_WIDTH-1:0]              waddr,
    input  logic [DATA_WIDTH-1:0]                 din,
    output logic                                  perr
`ifdef BRAM_PARITY_EN
    ,
    input  logic                                  perr_inject
`endif
);

    localparam int LANES = lane_count(DATA_WIDTH, BYTE_WIDTH);

    if (!read_latency_legal(READ_LATENCY) || (DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_params
        $error("bram_pipelined_sdp: illegal READ_LATENCY=%0d or DATA_WIDTH=%0d (FILENAME=%s)",
               READ_LATENCY, DATA_WIDTH, FILENAME);
    end

    logic [DATA_WIDTH-1:0]   core_rdata;
    logic [DATA_WIDTH-1:0]   stage_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] stage_valid_reg;

`ifdef BRAM_PARITY_EN
    logic [LANES-1:0] core_rpar;
    logic [LANES-1:0] stage_par [READ_LATENCY];
`endif

    bram_sdp_core #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .BYTE_WIDTH    (BYTE_WIDTH),
        .WRITE_MODE    (WRITE_MODE),
        .LANES         (LANES)
    ) u_core (
        .clock       (clock),
        .reset_n     (reset_n),
        .ren         (ren),
        .raddr       (raddr),
        .wen         (wen),
        .wmask       (wmask),
        .waddr       (waddr),
        .din         (din),
`ifdef BRAM_PARITY_EN
        .perr_inject (perr_inject),
        .rpar        (core_rpar),
`endif
        .rdata       (core_rdata)
    );

    assign stage_data[0] = core_rdata;
`ifdef BRAM_PARITY_EN
    assign stage_par[0]  = core_rpar;
`endif

    // Stages 2..READ_LATENCY load only behind a valid beat, so dout holds between responses.
    for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
        logic [DATA_WIDTH-1:0] data_reg;
`ifdef BRAM_PARITY_EN
        logic [LANES-1:0]      par_reg;
`endif
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                data_reg <= '0;
`ifdef BRAM_PARITY_EN
                par_reg  <= '0;
`endif
            end else if (stage_valid_reg[gi-1]) begin
                data_reg <= stage_data[gi-1];
`ifdef BRAM_PARITY_EN
                par_reg  <= stage_par[gi-1];
`endif
            end
        end
        assign stage_data[gi] = data_reg;
`ifdef BRAM_PARITY_EN
        assign stage_par[gi]  = par_reg;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_valid_reg <= '0;
        end else begin
            stage_valid_reg[0] <= ren;
            for (int i = 1; i < READ_LATENCY; i++) begin
                stage_valid_reg[i] <= stage_valid_reg[i-1];
            end
        end
    end

    assign dout       = stage_data[READ_LATENCY-1];
    assign dout_valid = stage_valid_reg[READ_LATENCY-1];

`ifdef BRAM_PARITY_EN
    logic [LANES-1:0] lane_err;
    for (genvar gi = 0; gi < LANES; gi++) begin : g_check
        assign lane_err[gi] = lane_parity(MAX_LANE_BITS'(dout[gi*BYTE_WIDTH +: BYTE_WIDTH]))
                              ^ stage_par[READ_LATENCY-1][gi];
    end
    assign perr = dout_valid & (|lane_err);
`else
    assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_bram_pipelined_sdp.sv
// Bench for bram_pipelined_sdp: eight instances (latency 1..4 x READ_FIRST/WRITE_FIRST) share stimulus;
// each is checked every cycle against a queue-based model, plus directed literal checks.
module tb_bram_pipelined_sdp;

    localparam int DW   = 16;
    localparam int AW   = 11;
    localparam int BW   = 8;
    localparam int LN   = DW / BW;
    localparam int NCFG = 8;
`ifdef BRAM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        int          due;
        logic [DW-1:0] data;
        logic        perr;
    } resp_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          ren = 1'b0;
    logic          wen = 1'b0;
    logic [AW-1:0] raddr = '0;
    logic [AW-1:0] waddr = '0;
    logic [LN-1:0] wmask = '0;
    logic [DW-1:0] din = '0;
    logic          perr_inject = 1'b0;

    logic [DW-1:0] dout_w  [NCFG];
    logic          valid_w [NCFG];
    logic          perr_w  [NCFG];

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] pat(input int a);
        return {8'(a) ^ 8'hC3, 8'(a)};
    endfunction

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int LAT = gi / 2 + 1;
        localparam int WM  = gi % 2;

        bram_pipelined_sdp #(
            .DATA_WIDTH    (DW),
            .ADDRESS_WIDTH (AW),
            .BYTE_WIDTH    (BW),
            .READ_LATENCY  (LAT),
            .WRITE_MODE    (WM),
            .FILENAME      ("")
        ) dut (
            .clock       (clock),
            .reset_n     (reset_n),
            .ren         (ren),
            .raddr       (raddr),
            .dout        (dout_w[gi]),
            .dout_valid  (valid_w[gi]),
            .wen         (wen),
            .wmask       (wmask),
            .waddr       (waddr),
            .din         (din),
            .perr        (perr_w[gi])
`ifdef BRAM_PARITY_EN
            ,
            .perr_inject (perr_inject)
`endif
        );

        // Model: words and injected-lane flags per address, responses queued with their due edge.
        logic [DW-1:0] mem_m [32];
        logic [LN-1:0] bad_m [32];
        resp_t         q [$];
        int            cyc = 0;
        logic [DW-1:0] last_m = '0;

        always @(posedge clock) begin
            logic [DW-1:0] w;
            logic          p;
            logic          exp_valid;
            logic          exp_perr;
            int            ra;
            int            wa;
            cyc++;
            ra = int'(raddr[4:0]);
            wa = int'(waddr[4:0]);
            if (!reset_n) begin
                q.delete();
                last_m = '0;
            end else begin
                if (ren) begin
                    w = mem_m[ra];
                    p = |bad_m[ra];
                    if (WM == 1 && wen && raddr == waddr) begin
                        p = 1'b0;
                        for (int l = 0; l < LN; l++) begin
                            if (wmask[l]) begin
                                w[l*BW +: BW] = din[l*BW +: BW];
                                p = p | (PAR_EN & perr_inject);
                            end else begin
                                p = p | bad_m[ra][l];
                            end
                        end
                    end
                    q.push_back('{due: cyc + LAT - 1, data: w, perr: p});
                end
                if (wen) begin
                    for (int l = 0; l < LN; l++) begin
                        if (wmask[l]) begin
                            mem_m[wa][l*BW +: BW] = din[l*BW +: BW];
                            bad_m[wa][l] = PAR_EN & perr_inject;
                        end
                    end
                end
            end
            #1;
            exp_valid = 1'b0;
            exp_perr  = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_valid = 1'b1;
                exp_perr  = q[0].perr;
                last_m    = q[0].data;
                void'(q.pop_front());
            end
            check($sformatf("cfg%0d cyc%0d dout_valid", gi, cyc), 32'(valid_w[gi]), 32'(exp_valid));
            check($sformatf("cfg%0d cyc%0d dout", gi, cyc), 32'(dout_w[gi]), 32'(last_m));
            check($sformatf("cfg%0d cyc%0d perr", gi, cyc), 32'(perr_w[gi]), 32'(exp_perr));
        end
    end

    task automatic drive(input logic r, input int ra, input logic w, input int wa,
                         input logic [DW-1:0] d, input logic [LN-1:0] m, input logic inj);
        @(negedge clock);
        ren         = r;
        raddr       = AW'(ra);
        wen         = w;
        waddr       = AW'(wa);
        din         = d;
        wmask       = m;
        perr_inject = inj;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 1'b0, 0, '0, '0, 1'b0);
    endtask

    // Single isolated read: every instance must show one valid beat exactly at its own latency.
    task automatic read_check(input string nm, input int a, input logic [DW-1:0] exp, input logic exp_p);
        idle(4);
        drive(1'b1, a, 1'b0, 0, '0, '0, 1'b0);
        for (int j = 1; j <= 5; j++) begin
            @(posedge clock);
            #2;
            ren = 1'b0;
            for (int c = 0; c < NCFG; c++) begin
                if (j == c / 2 + 1) begin
                    check($sformatf("%s cfg%0d valid@%0d", nm, c, j), 32'(valid_w[c]), 32'd1);
                    check($sformatf("%s cfg%0d dout", nm, c), 32'(dout_w[c]), 32'(exp));
                    check($sformatf("%s cfg%0d perr", nm, c), 32'(perr_w[c]), 32'(exp_p));
                end else begin
                    check($sformatf("%s cfg%0d valid@%0d", nm, c, j), 32'(valid_w[c]), 32'd0);
                end
            end
        end
    endtask

    function automatic logic [DW-1:0] stream_word(input int a);
        if (a == 5) return 16'hAB34;
        if (a == 7) return 16'h2222;
        return pat(a);
    endfunction

    initial begin
        logic [DW-1:0] got [$];
        int first;
        int last;
        int cnt;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        for (int a = 0; a < 32; a++) drive(1'b0, 0, 1'b1, a, pat(a), 2'b11, 1'b0);

        // Latency sweep
        drive(1'b0, 0, 1'b1, 16, 16'hBEEF, 2'b11, 1'b0);
        read_check("latency", 16, 16'hBEEF, 1'b0);

        // Byte mask
        drive(1'b0, 0, 1'b1, 5, 16'h1234, 2'b11, 1'b0);
        drive(1'b0, 0, 1'b1, 5, 16'hABCD, 2'b10, 1'b0);
        read_check("bytemask", 5, 16'hAB34, 1'b0);

        // Collision
        idle(4);
        drive(1'b0, 0, 1'b1, 7, 16'h1111, 2'b11, 1'b0);
        drive(1'b1, 7, 1'b1, 7, 16'h2222, 2'b11, 1'b0);
        idle(5);
        for (int c = 0; c < NCFG; c++)
            check($sformatf("collision cfg%0d", c), 32'(dout_w[c]), (c % 2 == 1) ? 32'h2222 : 32'h1111);
        read_check("collision_after", 7, 16'h2222, 1'b0);

        // Streaming, observed on the latency-3 READ_FIRST instance
        idle(4);
        first = -1;
        last  = -1;
        fork
            begin
                for (int a = 0; a < 16; a++) drive(1'b1, a, 1'b0, 0, '0, '0, 1'b0);
                idle(1);
            end
            begin
                for (int k = 0; k < 22; k++) begin
                    @(posedge clock);
                    #2;
                    if (valid_w[4]) begin
                        got.push_back(dout_w[4]);
                        if (first < 0) first = k;
                        last = k;
                    end
                end
            end
        join
        check("stream count", 32'(got.size()), 32'd16);
        check("stream contiguous", 32'(last - first), 32'd15);
        for (int i = 0; i < got.size() && i < 16; i++)
            check($sformatf("stream word%0d", i), 32'(got[i]), 32'(stream_word(i)));
        check("stream hold", 32'(dout_w[4]), 32'(stream_word(15)));

        // Reset mid-flight
        idle(4);
        drive(1'b1, 1, 1'b0, 0, '0, '0, 1'b0);
        drive(1'b1, 2, 1'b0, 0, '0, '0, 1'b0);
        drive(1'b1, 3, 1'b0, 0, '0, '0, 1'b0);
        reset_n = 1'b0;
        cnt = 0;
        @(posedge clock);
        #2;
        if (valid_w[6] || valid_w[7]) cnt++;
        @(negedge clock);
        reset_n = 1'b1;
        ren     = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock);
            #2;
            if (valid_w[6] || valid_w[7]) cnt++;
        end
        check("reset discards in-flight", 32'(cnt), 32'd0);
        read_check("post_reset", 2, 16'hC102, 1'b0);

`ifdef BRAM_PARITY_EN
        drive(1'b0, 0, 1'b1, 3, 16'h00FF, 2'b01, 1'b1);
        read_check("parity_inject", 3, 16'hC0FF, 1'b1);
        drive(1'b0, 0, 1'b1, 3, 16'h00FF, 2'b01, 1'b0);
        read_check("parity_clean", 3, 16'hC0FF, 1'b0);
`endif

        // Randomized traffic with frequent same-address collisions
        for (int k = 0; k < 3000; k++) begin
            int ra;
            int wa;
            ra = int'($urandom_range(0, 31));
            wa = ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
                  DW'($urandom), LN'($urandom), PAR_EN & ($urandom_range(0, 7) == 0));
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
